// File: rtl/async_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : async_fifo_rd_ctrl
//  Description : Read-domain controller of a dual-clock FIFO. Brings the
//                Gray-coded write pointer into rdclk through a flop chain,
//                keeps the binary and Gray read pointers, and produces the
//                registered empty / almost_empty / level / read-valid flags
//                plus a sticky underflow indication.
//  Revision    : 1.0 - initial release
// ============================================================================
module async_fifo_rd_ctrl #(
   parameter int ADDR_W        = 3,
   parameter int SYNC_STAGES   = 2,
   parameter int AEMPTY_THRESH = 1
) (
   input  logic              rdclk,
   input  logic              rst,
   input  logic              rdreq,
   input  logic              underflow_clr,
   input  logic [ADDR_W:0]   wrptr_gray,
   output logic [ADDR_W:0]   rdptr_gray,
   output logic [ADDR_W-1:0] rdaddr,
   output logic              rd_en,
   output logic              rd_valid,
   output logic              empty,
   output logic              almost_empty,
   output logic [ADDR_W:0]   rd_level,
   output logic              underflow
);

   localparam logic [ADDR_W:0] c_aempty_thresh = (ADDR_W+1)'(AEMPTY_THRESH);

   logic [ADDR_W:0] r_sync [SYNC_STAGES];
   logic [ADDR_W:0] r_rdbin;
   logic [ADDR_W:0] w_wq;
   logic [ADDR_W:0] w_wbin;
   logic [ADDR_W:0] w_rdbin_nxt;
   logic [ADDR_W:0] w_rdgray_nxt;
   logic [ADDR_W:0] w_level_nxt;
   logic            w_accept;

   // Synchroniser chain carrying the write pointer into the read clock domain.
   always_ff @(posedge rdclk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      end else begin
         r_sync[0] <= wrptr_gray;
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      end
   end

   assign w_wq = r_sync[SYNC_STAGES-1];

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
   genvar gi;
   generate
      for (gi = 0; gi <= ADDR_W; gi++) begin : g_gray2bin
         assign w_wbin[gi] = ^w_wq[ADDR_W:gi];
      end
   endgenerate

   // A read is only accepted when the FIFO is known non-empty; the empty flag
   // is pessimistic so this can never read past the write pointer.
   assign w_accept     = rdreq & ~empty;
   assign rd_en        = w_accept;
   assign w_rdbin_nxt  = r_rdbin + (ADDR_W+1)'(w_accept);
   assign w_rdgray_nxt = (w_rdbin_nxt >> 1) ^ w_rdbin_nxt;
   // Modular difference stays correct when either pointer wraps.
   assign w_level_nxt  = w_wbin - w_rdbin_nxt;
   assign rdaddr       = r_rdbin[ADDR_W-1:0];

   // Read pointers, status flags and sticky underflow, all updated each edge.
   always_ff @(posedge rdclk) begin
      if (rst) begin
         r_rdbin      <= '0;
         rdptr_gray   <= '0;
         empty        <= 1'b1;
         almost_empty <= 1'b1;
         rd_level     <= '0;
         rd_valid     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         r_rdbin      <= w_rdbin_nxt;
         rdptr_gray   <= w_rdgray_nxt;
         // Full-width compare including the wrap bit distinguishes empty from full.
         empty        <= (w_rdgray_nxt == w_wq);
         almost_empty <= (w_level_nxt <= c_aempty_thresh);
         rd_level     <= w_level_nxt;
         rd_valid     <= w_accept;
         // Set has priority over clear so a simultaneous event is never lost.
         underflow    <= (rdreq & empty) | (underflow & ~underflow_clr);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_async_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_async_fifo_rd_ctrl
//  Description : Self-checking bench for async_fifo_rd_ctrl with a count-based
//                reference model, directed scenarios and a random phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_async_fifo_rd_ctrl;

   localparam int ADDR_W = 3;
   localparam int SYNC   = 2;
   localparam int DEPTH  = 1 << ADDR_W;
   localparam int PMOD   = 2 * DEPTH;
   localparam int THRESH = 1;

   logic       rdclk = 1'b0;
   logic       rst = 1'b0;
   logic       rdreq = 1'b0;
   logic       underflow_clr = 1'b0;
   logic [3:0] wrptr_gray;
   logic [3:0] rdptr_gray;
   logic [2:0] rdaddr;
   logic       rd_en, rd_valid, empty, almost_empty, underflow;
   logic [3:0] rd_level;

   int n_tests = 0;
   int n_fail  = 0;
   int wr_cnt  = 0;
   logic [3:0] wp;

   assign wp = 4'(wr_cnt);
   assign wrptr_gray = wp ^ (wp >> 1);

   async_fifo_rd_ctrl #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC), .AEMPTY_THRESH(THRESH)) dut (
      .rdclk(rdclk), .rst(rst), .rdreq(rdreq), .underflow_clr(underflow_clr),
      .wrptr_gray(wrptr_gray), .rdptr_gray(rdptr_gray), .rdaddr(rdaddr),
      .rd_en(rd_en), .rd_valid(rd_valid), .empty(empty), .almost_empty(almost_empty),
      .rd_level(rd_level), .underflow(underflow)
   );

   always #5 rdclk = ~rdclk;

   task automatic check(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: counts reads, remembers what the write pointer was on
   // each past edge, and derives flags from plain modular arithmetic.
   int rd_cnt = 0;
   int hist [SYNC];
   bit check_en = 1'b0;
   bit m_empty = 1'b1, m_ae = 1'b1, m_valid = 1'b0, m_uf = 1'b0;
   int m_level = 0, m_rdbin = 0;

   always @(posedge rdclk) begin
      int wseen;
      bit acc;
      if (rst) begin
         for (int i = 0; i < SYNC; i++) hist[i] = 0;
         rd_cnt = 0; m_rdbin = 0;
         m_empty = 1; m_ae = 1; m_level = 0; m_valid = 0; m_uf = 0;
      end else begin
         wseen   = hist[SYNC-1];
         acc     = rdreq && !m_empty;
         m_uf    = (rdreq && m_empty) || (m_uf && !underflow_clr);
         rd_cnt  = rd_cnt + int'(acc);
         m_rdbin = rd_cnt % PMOD;
         m_level = (wseen - m_rdbin + PMOD) % PMOD;
         m_empty = (m_level == 0);
         m_ae    = (m_level <= THRESH);
         m_valid = acc;
         for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = wr_cnt % PMOD;
      end
   end

   // Every cycle, all outputs are compared with the model mid-period.
   always @(negedge rdclk) begin
      if (check_en) begin
         check("empty", int'(empty), int'(m_empty));
         check("almost_empty", int'(almost_empty), int'(m_ae));
         check("rd_level", int'(rd_level), m_level);
         check("rd_valid", int'(rd_valid), int'(m_valid));
         check("underflow", int'(underflow), int'(m_uf));
         check("rdaddr", int'(rdaddr), m_rdbin % DEPTH);
         check("rdptr_gray", int'(rdptr_gray), m_rdbin ^ (m_rdbin >> 1));
         check("rd_en", int'(rd_en), int'(rdreq && !m_empty));
      end
   end

   task automatic tick();
      @(posedge rdclk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; rdreq = 1'b0; underflow_clr = 1'b0; wr_cnt = 0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_empty"}, int'(empty), 1);
      check({tag, "_ae"}, int'(almost_empty), 1);
      check({tag, "_level"}, int'(rd_level), 0);
      check({tag, "_rdptr"}, int'(rdptr_gray), 0);
      check({tag, "_rdaddr"}, int'(rdaddr), 0);
      check({tag, "_valid"}, int'(rd_valid), 0);
      check({tag, "_uf"}, int'(underflow), 0);
   endtask

   initial begin
      int vcount;
      // Reset values
      rst = 1'b1;
      tick();
      check_en = 1'b1;
      tick();
      check_reset_vals("rst");
      rst = 1'b0;

      // Write pointer latency through the synchroniser
      wr_cnt = 1;
      tick(); check("sync_e1_empty", int'(empty), 1);
      tick(); check("sync_e2_empty", int'(empty), 1);
      tick(); check("sync_e3_empty", int'(empty), 0);
      check("sync_e3_level", int'(rd_level), 1);

      // Full FIFO drained by a long read burst
      wr_cnt = 8;
      repeat (4) tick();
      check("full_level", int'(rd_level), 8);
      check("full_ae", int'(almost_empty), 0);
      vcount = 0;
      rdreq = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         vcount += int'(rd_valid);
         if (k < 8) check("burst_rdaddr", int'(rdaddr), k);
         if (k == 6) check("burst_ae_l2", int'(almost_empty), 0);
         if (k == 7) check("burst_ae_l1", int'(almost_empty), 1);
         if (k == 8) check("burst_empty", int'(empty), 1);
      end
      check("burst_valid_count", vcount, 8);
      check("burst_rdptr", int'(rdptr_gray), 4'b1100);
      check("burst_uf", int'(underflow), 1);
      rdreq = 1'b0; underflow_clr = 1'b1;
      tick();
      underflow_clr = 1'b0;

      // Concurrent bursty writes and continuous reads, 20 entries total
      do_reset();
      for (int c = 0; c < 150; c++) begin
         rdreq = !m_empty;
         if (wr_cnt < 20 && (wr_cnt - rd_cnt) < DEPTH && $urandom_range(0, 3) != 0)
            wr_cnt++;
         tick();
      end
      rdreq = 1'b0;
      tick();
      check("stream_writes_done", wr_cnt, 20);
      check("stream_rdptr", int'(rdptr_gray), 4'b0110);
      check("stream_empty", int'(empty), 1);
      check("stream_level", int'(rd_level), 0);
      check("stream_uf", int'(underflow), 0);

      // Underflow set/clear priority
      rdreq = 1'b1;
      tick();
      check("uf_set", int'(underflow), 1);
      check("uf_rdaddr", int'(rdaddr), 4);
      check("uf_valid", int'(rd_valid), 0);
      underflow_clr = 1'b1;
      tick();
      check("uf_set_wins", int'(underflow), 1);
      rdreq = 1'b0;
      tick();
      check("uf_cleared", int'(underflow), 0);
      underflow_clr = 1'b0;

      // Reset in the middle of a read
      wr_cnt = 27;
      repeat (4) tick();
      rdreq = 1'b1;
      tick(); tick();
      check("mid_level", int'(rd_level), 5);
      rst = 1'b1; wr_cnt = 0;
      tick();
      check_reset_vals("midrst");
      rst = 1'b0;
      vcount = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         vcount += int'(rd_valid);
         check("post_rst_rdaddr", int'(rdaddr), 0);
      end
      check("post_rst_valid", vcount, 0);
      rdreq = 1'b0; underflow_clr = 1'b1;
      tick();
      underflow_clr = 1'b0;

      // Random traffic, including underflows and a reset partway through
      for (int c = 0; c < 400; c++) begin
         if (c == 200) begin
            rst = 1'b1; wr_cnt = 0; rdreq = 1'b0;
            tick();
            rst = 1'b0;
         end
         rdreq = 1'($urandom_range(0, 1));
         underflow_clr = ($urandom_range(0, 7) == 0);
         if ((wr_cnt - rd_cnt) < DEPTH && $urandom_range(0, 1) == 1)
            wr_cnt++;
         tick();
      end
      rdreq = 1'b0; underflow_clr = 1'b0;
      repeat (6) tick();
      check_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
